// File: rtl/parity_generator.sv
// Transmit-side parity generator: appends a parity bit to each payload word and pushes it
// to a FIFO through a two-entry (main + skid) buffer with a registered grant.
package all_types_pkg;
    typedef enum logic {ODD, EVEN} parity_mode_e;
    typedef enum logic {MSB, LSB} parity_pos_e;
endpackage

module parity_generator #(
    parameter int unsigned                 DATA_WIDTH        = 8,
    parameter all_types_pkg::parity_mode_e PARITY_MODE       = all_types_pkg::ODD,
    parameter all_types_pkg::parity_pos_e  PARITY_BIT_CHOICE = all_types_pkg::MSB,
    parameter int unsigned                 CNT_WIDTH         = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-2:0] data_i,
    input  logic                  inject_err_i,
    output logic                  grant_o,
    output logic                  push_valid_o,
    output logic [DATA_WIDTH-1:0] push_data_o,
    input  logic                  push_grant_i,
    output logic [CNT_WIDTH-1:0]  word_cnt_o
);

    logic                  main_valid_q;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  parity;
    logic [DATA_WIDTH-1:0] word;
    logic                  accept;
    logic                  xfer;

    // Grant depends only on state so the FIFO side never forms a combinational loop.
    assign grant_o = !skid_valid_q && !rst_i;
    assign accept  = valid_i && grant_o;
    assign xfer    = main_valid_q && push_grant_i;

    always_comb begin
        if (PARITY_MODE == all_types_pkg::EVEN) begin
            parity = ^data_i;
        end else begin
            parity = ~^data_i;
        end
        parity = parity ^ inject_err_i;
        if (PARITY_BIT_CHOICE == all_types_pkg::MSB) begin
            word = {parity, data_i};
        end else begin
            word = {data_i, parity};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            if (xfer) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (!main_valid_q || xfer) begin
                // Skid holds the older word, so it must drain into main first.
                if (skid_valid_q) begin
                    main_valid_q <= 1'b1;
                    main_data_q  <= skid_data_q;
                    skid_valid_q <= accept;
                    if (accept) begin
                        skid_data_q <= word;
                    end
                end else begin
                    main_valid_q <= accept;
                    if (accept) begin
                        main_data_q <= word;
                    end
                end
            end else if (accept) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= word;
            end
        end
    end

    assign push_valid_o = main_valid_q;
    assign push_data_o  = main_data_q;
    assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_parity_generator.sv
// Directed bench: drives two generators (ODD/MSB with 2-bit counter, EVEN/LSB with 16-bit
// counter) from shared stimulus and compares against hand-computed words.
module tb_parity_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [6:0] data;
    logic       inj;
    logic       pg;

    logic        grant_a, pv_a, grant_b, pv_b;
    logic [7:0]  pd_a, pd_b;
    logic [1:0]  cnt_a;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    parity_generator #(
        .DATA_WIDTH(8), .PARITY_MODE(all_types_pkg::ODD),
        .PARITY_BIT_CHOICE(all_types_pkg::MSB), .CNT_WIDTH(2)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .inject_err_i(inj),
        .grant_o(grant_a), .push_valid_o(pv_a), .push_data_o(pd_a),
        .push_grant_i(pg), .word_cnt_o(cnt_a)
    );

    parity_generator #(
        .DATA_WIDTH(8), .PARITY_MODE(all_types_pkg::EVEN),
        .PARITY_BIT_CHOICE(all_types_pkg::LSB), .CNT_WIDTH(16)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .inject_err_i(inj),
        .grant_o(grant_b), .push_valid_o(pv_b), .push_data_o(pd_b),
        .push_grant_i(pg), .word_cnt_o(cnt_b)
    );

    typedef struct {
        logic       valid;
        logic [6:0] data;
        logic       inj;
        logic       pg;
        logic       xfer;
        logic       exp_grant;
        logic       exp_pv;
        logic       chk_data;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] d, input logic i, input logic g);
        valid = v;
        data  = d;
        inj   = i;
        pg    = g;
    endtask

    task automatic check_state(input string name, input logic eg, input logic epv,
                               input logic chk, input logic [7:0] ea, input logic [7:0] eb);
        check({name, " grant_a"}, 32'(grant_a), 32'(eg));
        check({name, " grant_b"}, 32'(grant_b), 32'(eg));
        check({name, " pv_a"}, 32'(pv_a), 32'(epv));
        check({name, " pv_b"}, 32'(pv_b), 32'(epv));
        if (chk) begin
            check({name, " data_a"}, 32'(pd_a), 32'(ea));
            check({name, " data_b"}, 32'(pd_b), 32'(eb));
        end
        check({name, " cnt_a"}, 32'(cnt_a), 32'(exp_cnt % 4));
        check({name, " cnt_b"}, 32'(cnt_b), 32'(exp_cnt % 65536));
    endtask

    initial begin
        //         valid data   inj pg  xfer grant pv  chk  a      b
        vecs[0] = '{1'b1, 7'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h03};
        vecs[1] = '{1'b1, 7'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h83, 8'h06};
        vecs[2] = '{1'b1, 7'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7F, 8'hFF};
        vecs[3] = '{1'b1, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 8'h00};
        vecs[4] = '{1'b1, 7'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h02};
        vecs[5] = '{1'b1, 7'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h03};
        vecs[6] = '{1'b0, 7'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};

        rst = 1'b1;
        drive(1'b1, 7'h7F, 1'b0, 1'b1);
        #1;
        check("grant in reset", 32'(grant_a | grant_b), 32'd0);
        tick();
        tick();
        check_state("reset", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        rst = 1'b0;
        drive(1'b0, 7'h00, 1'b0, 1'b1);
        #1;
        check("grant after reset", 32'(grant_a & grant_b), 32'd1);

        // Streaming with push_grant held: one word per cycle, counter A wraps.
        for (int k = 0; k < 7; k++) begin
            drive(vecs[k].valid, vecs[k].data, vecs[k].inj, vecs[k].pg);
            tick();
            if (vecs[k].xfer) exp_cnt++;
            check_state($sformatf("stream%0d", k), vecs[k].exp_grant, vecs[k].exp_pv,
                        vecs[k].chk_data, vecs[k].exp_a, vecs[k].exp_b);
        end

        // Backpressure: main holds, skid fills, third word refused until drained.
        drive(1'b1, 7'h01, 1'b0, 1'b0);
        tick();
        check_state("bp hold1", 1'b1, 1'b1, 1'b1, 8'h01, 8'h03);
        drive(1'b1, 7'h02, 1'b0, 1'b0);
        tick();
        check_state("bp skid", 1'b0, 1'b1, 1'b1, 8'h01, 8'h03);
        drive(1'b1, 7'h03, 1'b0, 1'b0);
        tick();
        check_state("bp refuse", 1'b0, 1'b1, 1'b1, 8'h01, 8'h03);
        drive(1'b1, 7'h03, 1'b0, 1'b1);
        tick();
        exp_cnt++;
        check_state("bp drain1", 1'b1, 1'b1, 1'b1, 8'h02, 8'h05);
        tick();
        exp_cnt++;
        check_state("bp drain2", 1'b1, 1'b1, 1'b1, 8'h83, 8'h06);
        drive(1'b0, 7'h00, 1'b0, 1'b1);
        tick();
        exp_cnt++;
        check_state("bp drain3", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset with skid full: everything discarded, no transfer on the reset edge.
        drive(1'b1, 7'h01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'h02, 1'b0, 1'b0);
        tick();
        check_state("pre-rst", 1'b0, 1'b1, 1'b1, 8'h01, 8'h03);
        rst = 1'b1;
        drive(1'b1, 7'h03, 1'b0, 1'b1);
        #1;
        check("mid-rst grant", 32'(grant_a | grant_b), 32'd0);
        tick();
        exp_cnt = 0;
        rst = 1'b0;
        drive(1'b0, 7'h00, 1'b0, 1'b1);
        #1;
        check_state("post-rst", 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_state($sformatf("no stale%0d", k), 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        end

        // Injection after reset on a fresh word.
        drive(1'b1, 7'h03, 1'b1, 1'b0);
        tick();
        check_state("inj3", 1'b1, 1'b1, 1'b1, 8'h03, 8'h07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_generator.md
Name: parity_generator

Overview:
- Transmit-side partner of the parity checker: accepts payload words from the top level, computes a parity bit, and inserts it at the configured position.
- Pushes the complete DATA_WIDTH-bit word into the FIFO through a valid/grant handshake.
- A 2-entry skid buffer keeps full throughput with a registered grant_o.
- Provides parity-error injection for checker verification and a count of words pushed.

Parameters:
- DATA_WIDTH, 8, full word width written to the FIFO, parity bit included (>= 2).
- PARITY_MODE, ODD, all_types_pkg value ODD or EVEN; total count of 1s in the pushed word, parity bit included.
- PARITY_BIT_CHOICE, MSB, all_types_pkg value MSB or LSB; position of the parity bit in the pushed word.
- CNT_WIDTH, 16, width of word_cnt_o.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  top level presents a payload word
- data_i  input  DATA_WIDTH-1  payload word
- inject_err_i  input  1  sampled with an accepted word; inverts that word's parity bit
- grant_o  output  1  generator accepts data_i this cycle
- push_valid_o  output  1  word presented to the FIFO
- push_data_o  output  DATA_WIDTH  payload plus parity bit
- push_grant_i  input  1  FIFO accepts push_data_o this cycle
- word_cnt_o  output  CNT_WIDTH  number of words transferred to the FIFO

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset, sampled at rising edge with rst_i=1:
  - main and skid entries are invalidated.
  - push_valid_o=0, push_data_o=0, word_cnt_o=0.
  - grant_o=0 whenever rst_i=1 (combinational gate).
- Parity bit p = ^data_i for EVEN, ~^data_i for ODD; then p ^= inject_err_i.
- Word assembly:
  - MSB: {p, data_i}.
  - LSB: {data_i, p}.
  - Word is computed from data_i in the acceptance cycle and stored. No later recomputation.
- Accept: valid_i && grant_o at a rising edge.
- Transfer: push_valid_o && push_grant_i at a rising edge.
- Storage: main register drives push_valid_o/push_data_o directly. A skid register holds one extra word.
- grant_o = !skid_valid && !rst_i. It depends only on state, never combinationally on push_grant_i.
- Latency: a word accepted at edge N is on push_data_o after edge N when main was empty or drained at edge N.
- Throughput: 1 word/cycle when push_grant_i held 1.
- Edge updates:
  - main empty, or main transferred: main <- skid if skid valid (skid cleared, and the new accept goes into skid if one occurs); otherwise main <- accepted word.
  - main full and not transferred, with an accept: word goes to skid; grant_o=0 next cycle.
  - Accept and transfer in the same cycle with skid empty: main <- new word, push_valid_o stays 1.
- Stability: while push_valid_o=1 and push_grant_i=0, push_data_o is held constant. push_valid_o never drops without a transfer (except on reset).
- Ordering: words are strictly FIFO-ordered; nothing is dropped or duplicated.
- data_i and inject_err_i are ignored when valid_i=0 or grant_o=0.
- word_cnt_o increments by 1 on each transfer and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-operation: both entries are discarded; no transfer occurs on the reset edge; the counter returns to 0.

Test Plan:
- ODD/MSB, DATA_WIDTH=8, push_grant_i=1, data_i 7'h01 then 7'h03 -> push_data_o 8'h01 then 8'h83, one cycle after each accept; word_cnt_o=2.
- EVEN/LSB, data_i 7'h01 -> 8'h03; data_i 7'h7F -> 8'hFF; data_i 7'h00 -> 8'h00.
- Backpressure: push_grant_i=0, valid_i=1 with 7'h01, 7'h02, 7'h03 on consecutive cycles.
  - First word held on push_data_o; second accepted into skid; grant_o=0 from the third cycle and the third word is not accepted.
  - After push_grant_i=1, outputs are 01, 02, then 03 in order with no gap.
- Injection: ODD/MSB, data_i 7'h01 with inject_err_i=1 -> 8'h81; next word 7'h01 with inject_err_i=0 -> 8'h01.
- Counter wrap: CNT_WIDTH=2, 5 transfers -> word_cnt_o sequence 1, 2, 3, 0, 1.
- Reset mid-stream: skid full, rst_i=1 for one cycle -> push_valid_o=0 and grant_o=0 that cycle, word_cnt_o=0. Next cycle grant_o=1 and no stale words are emitted.
